// File: rtl/mat_result_serializer.sv
// -----------------------------------------------------------------------------
// mat_result_serializer
//
// Sink for the 2x2 matrix multiplier result stream. Every cycle that `done` is
// high, one complete result {w, x, y, z} is captured into a DEPTH-entry FIFO.
// The FIFO is drained one DW-bit element per cycle, in the order w, x, y, z,
// on a valid/ready interface. `almost_full` is fed back to the operand
// sequencer so that it stops issuing while multiplies are still in flight.
//
// Optional feature (macro RESULT_SAT16_EN):
//   defined   : out_data is the head element clamped to [-32768, 32767] and
//               sign-extended to DW bits; out_sat flags an altered value.
//   undefined : out_data is the full DW-bit element; out_sat is tied to 0.
//
// Parameters:
//   DEPTH     FIFO entries (one full result each), power of 2, >= 2
//   DW        element width, signed (>= 16 when RESULT_SAT16_EN is defined)
//   AF_MARGIN almost_full asserts when AF_MARGIN or fewer entries are free
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   done, w, x, y, z      result strobe and elements from the multiplier
//   out_data, out_valid   current element and its valid flag
//   out_ready             downstream accepts the current element
//   out_idx, out_last     element index (0=w .. 3=z), high with element z
//   out_sat               current element was clamped
//   almost_full           throttle request to the upstream sequencer
//   overflow              sticky: a result was dropped because the FIFO was full
//   level                 occupied FIFO entries
// -----------------------------------------------------------------------------
module mat_result_serializer #(
    parameter int DEPTH     = 8,
    parameter int DW        = 32,
    parameter int AF_MARGIN = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         done,
    input  logic signed [DW-1:0]         w,
    input  logic signed [DW-1:0]         x,
    input  logic signed [DW-1:0]         y,
    input  logic signed [DW-1:0]         z,
    output logic signed [DW-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [1:0]                   out_idx,
    output logic                         out_last,
    output logic                         out_sat,
    output logic                         almost_full,
    output logic                         overflow,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PW    = $clog2(DEPTH);
    localparam int LW    = $clog2(DEPTH+1);
    localparam int AF_TH = DEPTH - AF_MARGIN;

    // Element counter: which element of the head entry is presented.
    typedef enum logic [1:0] {S_W = 2'd0, S_X = 2'd1, S_Y = 2'd2, S_Z = 2'd3} elem_e;

    elem_e                 state_q, state_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  ovf_q, ovf_d;

    logic signed [DW-1:0]  mem_q [DEPTH][4];
    logic signed [DW-1:0]  head_elem;

    logic                  xfer;
    logic                  pop;
    logic                  full;
    logic                  wr;

`ifdef RESULT_SAT16_EN
    localparam logic signed [DW-1:0] SAT_MAX = DW'(32767);
    localparam logic signed [DW-1:0] SAT_MIN = -DW'(32768);

    function automatic logic signed [DW-1:0] clamp16(input logic signed [DW-1:0] v);
        if (v > SAT_MAX) return SAT_MAX;
        if (v < SAT_MIN) return SAT_MIN;
        return v;
    endfunction

    function automatic logic is_sat16(input logic signed [DW-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction
`endif

    assign xfer = (level_q != '0) && out_ready;
    // Only the transfer of element z retires the head entry.
    assign pop  = xfer && (state_q == S_Z);
    assign full = (level_q == LW'(DEPTH));
    // At full, a write still lands when the head entry retires on the same edge.
    assign wr   = done && (!full || pop);

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (xfer) begin
            case (state_q)
                S_W:     state_d = S_X;
                S_X:     state_d = S_Y;
                S_Y:     state_d = S_Z;
                default: state_d = S_W;
            endcase
        end

        // Pointers wrap naturally because DEPTH is a power of 2.
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr)  wr_ptr_d = wr_ptr_q + 1'b1;

        case ({wr, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (done && !wr) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_W;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Result storage carries no reset; empty slots are never presented.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q][0] <= w;
            mem_q[wr_ptr_q][1] <= x;
            mem_q[wr_ptr_q][2] <= y;
            mem_q[wr_ptr_q][3] <= z;
        end
    end

    assign out_valid   = (level_q != '0);
    assign out_idx     = state_q;
    assign out_last    = out_valid && (state_q == S_Z);
    assign level       = level_q;
    assign overflow    = ovf_q;
    assign almost_full = (int'(level_q) >= AF_TH);
    assign head_elem   = mem_q[rd_ptr_q][out_idx];

    // Data is forced to 0 while empty so the reset value holds without
    // resetting the storage array.
`ifdef RESULT_SAT16_EN
    assign out_data = out_valid ? clamp16(head_elem) : '0;
    assign out_sat  = out_valid && is_sat16(head_elem);
`else
    assign out_data = out_valid ? head_elem : '0;
    assign out_sat  = 1'b0;
`endif

endmodule

// File: tb/tb_mat_result_serializer.sv
module tb_mat_result_serializer;

    localparam int DEPTH     = 8;
    localparam int DW        = 32;
    localparam int AF_MARGIN = 2;
    localparam int LW        = $clog2(DEPTH+1);

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 done;
    logic signed [DW-1:0] w, x, y, z;
    logic signed [DW-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           out_idx;
    logic                 out_last;
    logic                 out_sat;
    logic                 almost_full;
    logic                 overflow;
    logic [LW-1:0]        level;

    mat_result_serializer #(.DEPTH(DEPTH), .DW(DW), .AF_MARGIN(AF_MARGIN)) dut (
        .clk(clk), .reset(reset), .done(done),
        .w(w), .x(x), .y(y), .z(z),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_last(out_last), .out_sat(out_sat),
        .almost_full(almost_full), .overflow(overflow), .level(level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Reference model: results buffered, position inside the head result, sticky drop flag.
    int m_res = 0;
    int m_idx = 0;
    bit m_ovf = 1'b0;

    // Scoreboard of expected element transfers.
    logic signed [DW-1:0] exp_data[$];
    int                   exp_idx[$];
    bit                   exp_sat[$];

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic signed [DW-1:0] model_data(input logic signed [DW-1:0] v);
`ifdef RESULT_SAT16_EN
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
`endif
        return v;
    endfunction

    function automatic bit model_sat(input logic signed [DW-1:0] v);
`ifdef RESULT_SAT16_EN
        return (v > 32767) || (v < -32768);
`else
        return (v != v);
`endif
    endfunction

    function automatic logic signed [DW-1:0] rnd_val();
        int b[4];
        b = '{32767, 32768, -32768, -32769};
        case ($urandom_range(0, 3))
            0:       return $signed($urandom_range(0, 100000)) - 50000;
            1:       return b[$urandom_range(0, 3)];
            2:       return $signed($urandom());
            default: return $signed($urandom_range(0, 200)) - 100;
        endcase
    endfunction

    // One clock cycle: drive inputs, predict at the negedge, update model after the posedge.
    task automatic step(input bit d, input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                        input logic signed [DW-1:0] c, input logic signed [DW-1:0] e, input bit r);
        bit tr, retire, acc;
        done = d; w = a; x = b; y = c; z = e; out_ready = r;
        @(negedge clk);
        tr     = (m_res > 0) && r;
        retire = tr && (m_idx == 3);
        acc    = d && ((m_res < DEPTH) || retire);
        @(posedge clk);
        if (tr) begin
            if (m_idx == 3) begin m_idx = 0; m_res--; end
            else m_idx++;
        end
        if (acc) begin
            m_res++;
            exp_data.push_back(model_data(a)); exp_idx.push_back(0); exp_sat.push_back(model_sat(a));
            exp_data.push_back(model_data(b)); exp_idx.push_back(1); exp_sat.push_back(model_sat(b));
            exp_data.push_back(model_data(c)); exp_idx.push_back(2); exp_sat.push_back(model_sat(c));
            exp_data.push_back(model_data(e)); exp_idx.push_back(3); exp_sat.push_back(model_sat(e));
        end else if (d) begin
            m_ovf = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input bit r);
        step(1'b0, 0, 0, 0, 0, r);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && m_res > 0; i++) idle(1'b1);
        chk("drain_empty", m_res, 0);
    endtask

    task automatic model_clear();
        m_res = 0; m_idx = 0; m_ovf = 1'b0;
        exp_data.delete(); exp_idx.delete(); exp_sat.delete();
    endtask

    task automatic reset_outputs_check(input string tag);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_idx"}, out_idx, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_sat"}, out_sat, 0);
        chk({tag, "_af"}, almost_full, 0);
        chk({tag, "_ovf"}, overflow, 0);
    endtask

    task automatic sync_reset();
        reset = 1'b1;
        model_clear();
        @(posedge clk); #1;
        reset_outputs_check("rst_sync");
        reset = 1'b0;
    endtask

    // Monitor: status against the model every cycle, element data against the scoreboard.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            chk("out_valid", out_valid, m_res > 0);
            chk("level", level, m_res);
            chk("almost_full", almost_full, m_res >= DEPTH - AF_MARGIN);
            chk("overflow", overflow, m_ovf);
            chk("out_idx_state", out_idx, m_idx);
            if (out_valid && out_ready) begin
                if (exp_data.size() == 0) begin
                    chk("unexpected_transfer", 1, 0);
                end else begin
                    logic signed [DW-1:0] ed;
                    int ei;
                    bit es;
                    ed = exp_data.pop_front();
                    ei = exp_idx.pop_front();
                    es = exp_sat.pop_front();
                    chk("xfer_data", out_data, ed);
                    chk("xfer_idx", out_idx, ei);
                    chk("xfer_last", out_last, ei == 3);
                    chk("xfer_sat", out_sat, es);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; done = 1'b0; out_ready = 1'b0;
        w = 0; x = 0; y = 0; z = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_outputs_check("rst_init");
        reset = 1'b0;
        mon_en = 1'b1;

        // Single result, ready held high.
        step(1'b1, 5, -3, 12, 0, 1'b1);
        drain();

        // Backpressure pattern.
        step(1'b1, 5, -3, 12, 0, 1'b0);
        begin
            bit pat[7];
            pat = '{1, 0, 0, 1, 1, 0, 1};
            for (int i = 0; i < 7; i++) idle(pat[i]);
        end
        drain();
        chk("bp_no_extra", exp_data.size(), 0);

        // Burst of DEPTH results, then one more to overflow.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 100 + i, 200 + i, -300 - i, 400 * i, 1'b0);
        chk("burst_level", level, DEPTH);
        chk("burst_af", almost_full, 1);
        chk("burst_ovf", overflow, 0);
        step(1'b1, 999, 999, 999, 999, 1'b0);
        chk("ovf_set", overflow, 1);
        chk("ovf_level", level, DEPTH);
        drain();
        chk("ovf_sticky", overflow, 1);

        // Full with simultaneous retire of the head and a new write.
        sync_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, i, -i, 2 * i, 3 * i, 1'b0);
        for (int i = 0; i < 8 && m_idx != 3; i++) idle(1'b1);
        chk("full_pop_idx", out_idx, 3);
        step(1'b1, 7777, -7777, 1, 2, 1'b1);
        chk("full_pop_level", level, DEPTH);
        chk("full_pop_ovf", overflow, 0);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit d;
            d = ($urandom_range(0, 99) < ((i % 150) < 30 ? 90 : 30));
            step(d, rnd_val(), rnd_val(), rnd_val(), rnd_val(), $urandom_range(0, 99) < 70);
        end
        drain();

        // Asynchronous reset while element y is presented.
        sync_reset();
        step(1'b1, 21, 22, 23, 24, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("mid_idx", out_idx, 2);
        #1 reset = 1'b1;
        #1;
        reset_outputs_check("rst_async");
        model_clear();
        reset = 1'b0;
        step(1'b1, 31, 32, 33, 34, 1'b1);
        chk("fresh_idx", out_idx, 0);
        chk("fresh_data", out_data, 31);
        drain();

        // Saturation corner values.
        step(1'b1, 40000, -40000, 32767, -1, 1'b1);
        drain();

        chk("scoreboard_empty", exp_data.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
